// File: rtl/led_matrix_pkg.sv
// Shared types for the HUB75 capture path: pixel colour type, FSM states and
// channel indices into rgb_t.
package led_matrix_pkg;

  localparam int LM_COLOR_DEPTH = 4;

  localparam int CH_R = 2;
  localparam int CH_G = 1;
  localparam int CH_B = 0;

  typedef logic [2:0][LM_COLOR_DEPTH-1:0] rgb_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_READOUT
  } cap_state_t;

endpackage

// File: rtl/hub75_plane_store.sv
// Bit-plane store for one row pair: the whole shift buffer is written as one
// plane slice, and one column of one half is read back per cycle, registered.
module hub75_plane_store
  import led_matrix_pkg::*;
#(
  parameter  int COLS  = 64,
  parameter  int DEPTH = LM_COLOR_DEPTH,
  localparam int COL_W = $clog2(COLS),
  localparam int PL_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_we,
  input  logic [PL_W-1:0]               i_wr_plane,
  input  logic [COLS-1:0][1:0][2:0]     i_wr_data,
  input  logic                          i_rd_en,
  input  logic [COL_W-1:0]              i_rd_col,
  input  logic                          i_rd_lower,
  output logic [2:0][DEPTH-1:0]         o_rd_rgb
);

  // [col][half: 1=upper, 0=lower][channel][plane]
  logic [COLS-1:0][1:0][2:0][DEPTH-1:0] r_mem;
  logic [2:0][DEPTH-1:0]                r_rd_rgb;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int c = 0; c < COLS; c++) begin
        for (int h = 0; h < 2; h++) begin
          r_mem[c][h][CH_R][i_wr_plane] <= i_wr_data[c][h][CH_R];
          r_mem[c][h][CH_G][i_wr_plane] <= i_wr_data[c][h][CH_G];
          r_mem[c][h][CH_B][i_wr_plane] <= i_wr_data[c][h][CH_B];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_rd_rgb <= '0;
    else
      r_rd_rgb <= i_rd_en ? r_mem[i_rd_col][~i_rd_lower] : '0;
  end

  assign o_rd_rgb = r_rd_rgb;

endmodule

// File: rtl/hub75_capture.sv
// HUB75 receive decoder: samples the panel pins, rebuilds bit-planes per row
// pair and replays the pair as a gapless 2*PANEL_COLS pixel stream.
module hub75_capture
  import led_matrix_pkg::*;
#(
  parameter  int PANEL_ROWS  = 64,
  parameter  int PANEL_COLS  = 64,
  parameter  int COLOR_DEPTH = LM_COLOR_DEPTH,
  localparam int PAIR_W      = $clog2(PANEL_ROWS/2),
  localparam int ROW_W       = $clog2(PANEL_ROWS),
  localparam int COL_W       = $clog2(PANEL_COLS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         matrix_clk,
  input  logic [PAIR_W-1:0]            matrix_row,
  input  logic [2:0]                   matrix_rgb_upper,
  input  logic [2:0]                   matrix_rgb_lower,
  input  logic                         matrix_oe_n,
  input  logic                         matrix_stb,
  output logic                         valid_out,
  output logic [2:0][COLOR_DEPTH-1:0]  rgb_out,
  output logic [ROW_W-1:0]             row_out,
  output logic [COL_W-1:0]             col_out,
  output logic                         sof_out,
  output logic                         err_len,
  output logic                         err_seq,
  output logic                         err_ovf
);

  localparam int CNT_W = $clog2(PANEL_COLS + 1);
  localparam int RD_W  = $clog2(2*PANEL_COLS);
  localparam int PL_W  = (COLOR_DEPTH > 1) ? $clog2(COLOR_DEPTH) : 1;

  // input sampling and edge detect
  logic              r_s1_mclk, r_s1_stb, r_s1_oe_n;
  logic [PAIR_W-1:0] r_s1_row;
  logic [2:0]        r_s1_up, r_s1_lo;
  logic              r_s2_mclk, r_s2_stb;
  logic              w_mclk_rise, w_stb_rise;
  logic              w_unused;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_mclk <= 1'b0;
      r_s1_stb  <= 1'b0;
      r_s1_oe_n <= 1'b0;
      r_s1_row  <= '0;
      r_s1_up   <= '0;
      r_s1_lo   <= '0;
      r_s2_mclk <= 1'b0;
      r_s2_stb  <= 1'b0;
    end else begin
      r_s1_mclk <= matrix_clk;
      r_s1_stb  <= matrix_stb;
      r_s1_oe_n <= matrix_oe_n;
      r_s1_row  <= matrix_row;
      r_s1_up   <= matrix_rgb_upper;
      r_s1_lo   <= matrix_rgb_lower;
      r_s2_mclk <= r_s1_mclk;
      r_s2_stb  <= r_s1_stb;
    end
  end

  assign w_mclk_rise = r_s1_mclk & ~r_s2_mclk;
  assign w_stb_rise  = r_s1_stb  & ~r_s2_stb;
  // OE is observed for monitoring only; it never steers the decode.
  assign w_unused    = r_s1_oe_n;

  // The strobe is evaluated one cycle after detection, so a shift edge seen in
  // the same cycle as the strobe edge is already counted.
  logic              r_stb_evt;
  logic [PAIR_W-1:0] r_evt_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stb_evt <= 1'b0;
      r_evt_row <= '0;
    end else begin
      r_stb_evt <= w_stb_rise;
      if (w_stb_rise) r_evt_row <= r_s1_row;
    end
  end

  // shift capture
  logic [PANEL_COLS-1:0][1:0][2:0] r_shift_buf;
  logic [CNT_W-1:0]                r_shift_cnt;
  logic [CNT_W-1:0]                w_cnt_base;
  logic [COL_W-1:0]                w_wr_col;
  logic                            w_shift_we;

  // A strobe being evaluated clears the count under any shift landing alongside.
  assign w_cnt_base = r_stb_evt ? '0 : r_shift_cnt;
  assign w_shift_we = w_mclk_rise && (w_cnt_base != CNT_W'(PANEL_COLS));
  assign w_wr_col   = COL_W'(PANEL_COLS-1) - w_cnt_base[COL_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_shift_cnt <= '0;
    else if (w_shift_we) r_shift_cnt <= w_cnt_base + 1'b1;
    else                 r_shift_cnt <= w_cnt_base;
  end

  always_ff @(posedge clk) begin
    if (w_shift_we) r_shift_buf[w_wr_col] <= {r_s1_up, r_s1_lo};
  end

  // FSM and plane sequencing
  cap_state_t        r_state, w_state_nxt;
  logic [PL_W-1:0]   r_plane, w_plane_nxt, w_wr_plane;
  logic [PAIR_W-1:0] r_cur_row, w_row_nxt;
  logic [RD_W-1:0]   r_rd_cnt;
  logic              w_we, w_rd_last, w_rd_act;
  logic              w_err_len, w_err_seq, w_err_ovf;

  assign w_rd_act  = (r_state == ST_READOUT);
  assign w_rd_last = (r_rd_cnt == RD_W'(2*PANEL_COLS-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_plane_nxt = r_plane;
    w_wr_plane  = r_plane;
    w_row_nxt   = r_cur_row;
    w_we        = 1'b0;
    w_err_len   = 1'b0;
    w_err_seq   = 1'b0;
    w_err_ovf   = 1'b0;
    case (r_state)
      ST_READOUT: begin
        w_err_ovf = r_stb_evt;
        if (w_rd_last) w_state_nxt = ST_IDLE;
      end
      default: begin
        if (r_stb_evt) begin
          if (r_shift_cnt != CNT_W'(PANEL_COLS)) begin
            w_err_len = 1'b1;
          end else begin
            w_we      = 1'b1;
            w_row_nxt = r_evt_row;
            if ((r_evt_row != r_cur_row) && (r_plane != '0)) begin
              // restart the pair on the new row with this data as plane 0
              w_err_seq   = 1'b1;
              w_wr_plane  = '0;
              w_plane_nxt = PL_W'(1);
              w_state_nxt = ST_ACCUM;
            end else if (r_plane == PL_W'(COLOR_DEPTH-1)) begin
              w_plane_nxt = '0;
              w_state_nxt = ST_READOUT;
            end else begin
              w_plane_nxt = r_plane + 1'b1;
              w_state_nxt = ST_ACCUM;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_plane   <= '0;
      r_cur_row <= '0;
      r_rd_cnt  <= '0;
    end else begin
      r_plane   <= w_plane_nxt;
      r_cur_row <= w_row_nxt;
      r_rd_cnt  <= (w_rd_act && !w_rd_last) ? r_rd_cnt + 1'b1 : '0;
    end
  end

  hub75_plane_store #(
    .COLS  (PANEL_COLS),
    .DEPTH (COLOR_DEPTH)
  ) u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we       (w_we),
    .i_wr_plane (w_wr_plane),
    .i_wr_data  (r_shift_buf),
    .i_rd_en    (w_rd_act),
    .i_rd_col   (r_rd_cnt[COL_W-1:0]),
    .i_rd_lower (r_rd_cnt[COL_W]),
    .o_rd_rgb   (rgb_out)
  );

  // output sideband, aligned with the registered store read
  logic             r_valid, r_sof, r_err_len, r_err_seq, r_err_ovf;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_sof     <= 1'b0;
      r_row     <= '0;
      r_col     <= '0;
      r_err_len <= 1'b0;
      r_err_seq <= 1'b0;
      r_err_ovf <= 1'b0;
    end else begin
      r_valid   <= w_rd_act;
      r_sof     <= w_rd_act && (r_rd_cnt == '0) && (r_cur_row == '0);
      r_row     <= w_rd_act ? {r_rd_cnt[COL_W], r_cur_row} : '0;
      r_col     <= w_rd_act ? r_rd_cnt[COL_W-1:0] : '0;
      r_err_len <= w_err_len;
      r_err_seq <= w_err_seq;
      r_err_ovf <= w_err_ovf;
    end
  end

  assign valid_out = r_valid;
  assign sof_out   = r_sof;
  assign row_out   = r_row;
  assign col_out   = r_col;
  assign err_len   = r_err_len;
  assign err_seq   = r_err_seq;
  assign err_ovf   = r_err_ovf;

endmodule

// File: tb/tb_hub75_capture.sv
// Directed bench for hub75_capture: the bench plays the HUB75 driver side and
// checks decoded row pairs, latency, error pulses and reset abort.
module tb_hub75_capture;

  localparam int ROWS  = 64;
  localparam int COLS  = 64;
  localparam int DEPTH = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic matrix_clk = 1'b0, matrix_oe_n = 1'b1, matrix_stb = 1'b0;
  logic [4:0] matrix_row = '0;
  logic [2:0] matrix_rgb_upper = '0, matrix_rgb_lower = '0;
  logic       valid_out, sof_out, err_len, err_seq, err_ovf;
  logic [2:0][DEPTH-1:0] rgb_out;
  logic [5:0] row_out, col_out;

  int n_checks = 0, n_errors = 0;

  logic [11:0] img_up [COLS];
  logic [11:0] img_lo [COLS];

  int pix_cnt = 0, sof_cnt = 0, sof_at = -1, len_cnt = 0, seq_cnt = 0, ovf_cnt = 0;
  logic [11:0] got_rgb [256];
  logic [5:0]  got_row [256];
  logic [5:0]  got_col [256];

  hub75_capture #(.PANEL_ROWS(ROWS), .PANEL_COLS(COLS), .COLOR_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .matrix_clk(matrix_clk), .matrix_row(matrix_row),
    .matrix_rgb_upper(matrix_rgb_upper), .matrix_rgb_lower(matrix_rgb_lower),
    .matrix_oe_n(matrix_oe_n), .matrix_stb(matrix_stb), .valid_out(valid_out),
    .rgb_out(rgb_out), .row_out(row_out), .col_out(col_out), .sof_out(sof_out),
    .err_len(err_len), .err_seq(err_seq), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  // pixel/event collector; tasks only read these
  always @(negedge clk) begin
    if (sof_out) begin sof_cnt = sof_cnt + 1; sof_at = pix_cnt; end
    if (valid_out) begin
      got_rgb[pix_cnt % 256] = rgb_out;
      got_row[pix_cnt % 256] = row_out;
      got_col[pix_cnt % 256] = col_out;
      pix_cnt = pix_cnt + 1;
    end
    if (err_len) len_cnt = len_cnt + 1;
    if (err_seq) seq_cnt = seq_cnt + 1;
    if (err_ovf) ovf_cnt = ovf_cnt + 1;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // first bit shifted lands in the far column
  task automatic shift_plane(input int row, input int p, input int nedges);
    int col;
    matrix_row = 5'(row);
    for (int i = 0; i < nedges; i++) begin
      col = COLS - 1 - i;
      matrix_rgb_upper = {img_up[col][8+p], img_up[col][4+p], img_up[col][p]};
      matrix_rgb_lower = {img_lo[col][8+p], img_lo[col][4+p], img_lo[col][p]};
      matrix_clk = 1'b1; tick();
      matrix_clk = 1'b0; tick();
    end
  endtask

  task automatic strobe();
    matrix_stb = 1'b1; tick();
    matrix_stb = 1'b0;
  endtask

  task automatic send_planes(input int row, input int p0, input int p1);
    for (int p = p0; p <= p1; p++) begin
      shift_plane(row, p, COLS);
      strobe();
    end
  endtask

  task automatic set_img(input int mu, input int au, input int ml, input int al);
    for (int c = 0; c < COLS; c++) begin
      img_up[c] = 12'(c*mu + au);
      img_lo[c] = 12'(c*ml + al);
    end
  endtask

  task automatic wait_pix(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (pix_cnt >= target) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  // number of the 128 collected pixels from 'start' that differ from the image
  function automatic int count_bad(input int row, input int start);
    int idx, bad;
    logic [11:0] e;
    bad = 0;
    for (int n = 0; n < 2*COLS; n++) begin
      idx = (start + n) % 256;
      e = (n < COLS) ? img_up[n] : img_lo[n-COLS];
      if (got_rgb[idx] !== e || got_row[idx] !== 6'(row + (n/COLS)*(ROWS/2)) ||
          got_col[idx] !== 6'(n % COLS)) bad++;
    end
    return bad;
  endfunction

  task automatic test_reset();
    repeat (3) tick();
    @(negedge clk);
    n_checks++; if (valid_out !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    n_checks++; if (rgb_out !== 12'h000) begin n_errors++; $display("FAIL reset_rgb: got %h want 000", rgb_out); end
    n_checks++; if (row_out !== 6'd0 || col_out !== 6'd0) begin n_errors++; $display("FAIL reset_rowcol: got %0d/%0d want 0/0", row_out, col_out); end
    n_checks++; if ({sof_out, err_len, err_seq, err_ovf} !== 4'b0) begin n_errors++; $display("FAIL reset_flags: got %b want 0000", {sof_out, err_len, err_seq, err_ovf}); end
    tick(); rst_n = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_checks++; if ({valid_out, sof_out, err_len, err_seq, err_ovf} !== 5'b0) begin n_errors++; $display("FAIL idle_after_reset: got %b want 00000", {valid_out, sof_out, err_len, err_seq, err_ovf}); end
  endtask

  task automatic test_ramp();
    int start, sof0, run;
    bit ok;
    for (int c = 0; c < COLS; c++) begin img_up[c] = 12'h000; img_lo[c] = 12'h000; end
    for (int c = 0; c < 16; c++) img_up[c] = 12'(c);
    img_up[31] = 12'h080; img_up[32] = 12'h080;
    for (int c = 56; c < 64; c++) img_up[c] = 12'hF00;
    start = pix_cnt; sof0 = sof_cnt;
    send_planes(0, 0, 2);
    shift_plane(0, 3, COLS);
    strobe();
    @(negedge clk); @(negedge clk); @(negedge clk);
    n_checks++; if (valid_out !== 1'b0) begin n_errors++; $display("FAIL ramp_lat_k2: valid got %b want 0", valid_out); end
    @(negedge clk);
    n_checks++; if (valid_out !== 1'b1 || sof_out !== 1'b1) begin n_errors++; $display("FAIL ramp_lat_k3: valid/sof got %b/%b want 1/1", valid_out, sof_out); end
    run = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!valid_out) break;
      run++;
    end
    n_checks++; if (run !== 2*COLS) begin n_errors++; $display("FAIL ramp_burst_len: got %0d want %0d", run, 2*COLS); end
    wait_pix(start + 2*COLS, ok);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL ramp_timeout: got %0d pixels want %0d", pix_cnt - start, 2*COLS); end
    n_checks++; if (count_bad(0, start) !== 0) begin n_errors++; $display("FAIL ramp_pixels: got %0d bad pixels want 0", count_bad(0, start)); end
    n_checks++; if (sof_cnt - sof0 !== 1 || sof_at !== start) begin n_errors++; $display("FAIL ramp_sof: got %0d sof at %0d want 1 at %0d", sof_cnt - sof0, sof_at, start); end
    n_checks++; if (len_cnt + seq_cnt + ovf_cnt !== 0) begin n_errors++; $display("FAIL ramp_errs: got %0d error pulses want 0", len_cnt + seq_cnt + ovf_cnt); end
  endtask

  task automatic test_last_row();
    int start, sof0;
    bit ok;
    for (int c = 0; c < COLS; c++) begin img_up[c] = 12'(c*37 + 3); img_lo[c] = 12'hFFF; end
    start = pix_cnt; sof0 = sof_cnt;
    send_planes(31, 0, 3);
    wait_pix(start + 2*COLS, ok);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL row31_timeout: got %0d pixels want %0d", pix_cnt - start, 2*COLS); end
    n_checks++; if (count_bad(31, start) !== 0) begin n_errors++; $display("FAIL row31_pixels: got %0d bad pixels want 0", count_bad(31, start)); end
    n_checks++; if (got_row[(start + 2*COLS - 1) % 256] !== 6'd63 || got_rgb[(start + 2*COLS - 1) % 256] !== 12'hFFF) begin
      n_errors++; $display("FAIL row31_last: got row %0d rgb %h want 63 fff", got_row[(start + 2*COLS - 1) % 256], got_rgb[(start + 2*COLS - 1) % 256]); end
    n_checks++; if (sof_cnt !== sof0) begin n_errors++; $display("FAIL row31_sof: got %0d extra sof want 0", sof_cnt - sof0); end
  endtask

  task automatic test_short_shift();
    int start, len0, seq0;
    bit ok;
    set_img(73, 5, 151, 9);
    start = pix_cnt; len0 = len_cnt; seq0 = seq_cnt;
    send_planes(5, 0, 1);
    shift_plane(5, 2, COLS - 1);
    strobe();
    @(negedge clk); @(negedge clk);
    n_checks++; if (err_len !== 1'b0) begin n_errors++; $display("FAIL short_k1: err_len got %b want 0", err_len); end
    @(negedge clk);
    n_checks++; if (err_len !== 1'b1) begin n_errors++; $display("FAIL short_k2: err_len got %b want 1", err_len); end
    @(negedge clk);
    n_checks++; if (err_len !== 1'b0 || valid_out !== 1'b0) begin n_errors++; $display("FAIL short_k3: err_len/valid got %b/%b want 0/0", err_len, valid_out); end
    send_planes(5, 2, 3);
    wait_pix(start + 2*COLS, ok);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL short_timeout: got %0d pixels want %0d", pix_cnt - start, 2*COLS); end
    n_checks++; if (count_bad(5, start) !== 0) begin n_errors++; $display("FAIL short_pixels: got %0d bad pixels want 0", count_bad(5, start)); end
    n_checks++; if (len_cnt - len0 !== 1 || seq_cnt !== seq0) begin n_errors++; $display("FAIL short_errcnt: got len %0d seq %0d want 1 0", len_cnt - len0, seq_cnt - seq0); end
  endtask

  task automatic test_row_change();
    int start, seq0, len0;
    bit ok;
    start = pix_cnt; seq0 = seq_cnt; len0 = len_cnt;
    set_img(29, 1, 11, 2);
    send_planes(3, 0, 1);
    set_img(53, 7, 97, 4);
    send_planes(4, 0, 3);
    wait_pix(start + 2*COLS, ok);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL rowchg_timeout: got %0d pixels want %0d", pix_cnt - start, 2*COLS); end
    n_checks++; if (seq_cnt - seq0 !== 1) begin n_errors++; $display("FAIL rowchg_err_seq: got %0d pulses want 1", seq_cnt - seq0); end
    n_checks++; if (count_bad(4, start) !== 0) begin n_errors++; $display("FAIL rowchg_pixels: got %0d bad pixels want 0", count_bad(4, start)); end
    n_checks++; if (len_cnt !== len0) begin n_errors++; $display("FAIL rowchg_err_len: got %0d pulses want 0", len_cnt - len0); end
  endtask

  task automatic test_overflow();
    int start, ovf0, len0;
    bit ok;
    set_img(19, 200, 41, 77);
    start = pix_cnt; ovf0 = ovf_cnt; len0 = len_cnt;
    send_planes(7, 0, 3);
    repeat (11) tick();
    strobe();
    wait_pix(start + 2*COLS, ok);
    repeat (10) tick();
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL ovf_timeout: got %0d pixels want %0d", pix_cnt - start, 2*COLS); end
    n_checks++; if (ovf_cnt - ovf0 !== 1) begin n_errors++; $display("FAIL ovf_pulse: got %0d pulses want 1", ovf_cnt - ovf0); end
    n_checks++; if (count_bad(7, start) !== 0) begin n_errors++; $display("FAIL ovf_pixels: got %0d bad pixels want 0", count_bad(7, start)); end
    n_checks++; if (pix_cnt - start !== 2*COLS || len_cnt !== len0) begin n_errors++; $display("FAIL ovf_count: got %0d pixels %0d len want %0d 0", pix_cnt - start, len_cnt - len0, 2*COLS); end
  endtask

  task automatic test_reset_mid();
    int start, at_rst;
    bit ok;
    set_img(13, 21, 17, 99);
    start = pix_cnt;
    send_planes(9, 0, 3);
    wait_pix(start + 40, ok);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL rstmid_timeout: got %0d pixels want 40", pix_cnt - start); end
    #2 rst_n = 1'b0;
    #1;
    at_rst = pix_cnt;
    n_checks++; if ({valid_out, sof_out, err_len, err_seq, err_ovf} !== 5'b0 || rgb_out !== 12'h000 || row_out !== 6'd0 || col_out !== 6'd0) begin
      n_errors++; $display("FAIL rstmid_outputs: got v%b rgb %h row %0d col %0d want all 0", valid_out, rgb_out, row_out, col_out); end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    n_checks++; if (pix_cnt !== at_rst) begin n_errors++; $display("FAIL rstmid_resume: got %0d extra pixels want 0", pix_cnt - at_rst); end
    set_img(61, 8, 3, 150);
    start = pix_cnt;
    send_planes(10, 0, 3);
    wait_pix(start + 2*COLS, ok);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL rstmid_next_timeout: got %0d pixels want %0d", pix_cnt - start, 2*COLS); end
    n_checks++; if (count_bad(10, start) !== 0) begin n_errors++; $display("FAIL rstmid_next_pixels: got %0d bad pixels want 0", count_bad(10, start)); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_last_row();
    test_short_shift();
    test_row_change();
    test_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
